// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display definitions: framebuffer geometry, byte address type
// and the draw engine state encoding. The scan-out path imports this too.
package chip8_pkg;

  localparam int FB_WIDTH  = 64;
  localparam int FB_HEIGHT = 32;
  localparam int FB_BYTES  = 256;

  typedef logic [7:0] fb_addr_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_RD_L,
    ST_WR_L,
    ST_RD_R,
    ST_WR_R,
    ST_NEXT,
    ST_DONE
  } draw_state_t;

endpackage

// File: rtl/chip8_draw_engine_if.sv
// Command, sprite-memory and framebuffer port bundle of the draw engine.
// slave = the engine itself, master = core / memories around it.
interface chip8_draw_engine_if;
  import chip8_pkg::*;

  logic        draw_in;
  logic        clear_in;
  logic [5:0]  x_in;
  logic [4:0]  y_in;
  logic [3:0]  n_in;
  logic [11:0] i_in;
  logic [11:0] mem_addr_out;
  logic [7:0]  mem_data_in;
  fb_addr_t    fb_addr_out;
  logic [7:0]  fb_data_in;
  logic [7:0]  fb_data_out;
  logic        fb_we_out;
  logic        busy_out;
  logic        done_out;
  logic        collision_out;

  modport slave (
    input  draw_in, clear_in, x_in, y_in, n_in, i_in, mem_data_in, fb_data_in,
    output mem_addr_out, fb_addr_out, fb_data_out, fb_we_out,
           busy_out, done_out, collision_out
  );

  modport master (
    output draw_in, clear_in, x_in, y_in, n_in, i_in, mem_data_in, fb_data_in,
    input  mem_addr_out, fb_addr_out, fb_data_out, fb_we_out,
           busy_out, done_out, collision_out
  );

endinterface

// File: rtl/chip8_draw_engine.sv
// CHIP-8 DRW / CLS executor. Reads sprite bytes from main memory, XORs them
// into the 64x32 framebuffer (one or two bytes per row depending on x
// alignment) with right/bottom clipping, and accumulates the VF collision.
module chip8_draw_engine
  import chip8_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int FB_LATENCY  = 2
) (
  input logic               clk_in,
  input logic               rst_in,
  chip8_draw_engine_if.slave bus
);

  localparam int WAIT_MAX = (MEM_LATENCY > FB_LATENCY) ? MEM_LATENCY : FB_LATENCY;
  localparam int WAIT_W   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] MEM_LAST = WAIT_W'(MEM_LATENCY);
  localparam logic [WAIT_W-1:0] FB_LAST  = WAIT_W'(FB_LATENCY);

  draw_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        r_q, r_d;
  fb_addr_t          clr_q, clr_d;
  logic [11:0]       mem_addr_q, mem_addr_d;
  fb_addr_t          fb_addr_q, fb_addr_d;
  logic [7:0]        fb_data_q, fb_data_d;
  logic              fb_we_q, fb_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              coll_q, coll_d;

  logic [5:0]        x_q, x_d;
  logic [4:0]        y_q, y_d;
  logic [3:0]        n_q, n_d;
  logic [11:0]       i_q, i_d;
  logic [7:0]        s_q, s_d;

  logic [2:0]        ofs;
  logic [2:0]        col;
  logic [4:0]        row;
  logic [4:0]        r_inc;
  logic [15:0]       spread;
  logic [7:0]        left_byte;
  logic [7:0]        right_byte;

  // Sprite byte split across two framebuffer bytes by the sub-byte offset.
  assign ofs        = x_q[2:0];
  assign col        = x_q[5:3];
  assign row        = y_q + {1'b0, r_q};
  assign r_inc      = {1'b0, r_q} + 5'd1;
  assign spread     = {s_q, 8'h00} >> ofs;
  assign left_byte  = spread[15:8];
  assign right_byte = spread[7:0];

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state plus next value of every registered output and counter.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    r_d        = r_q;
    clr_d      = clr_q;
    mem_addr_d = mem_addr_q;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    fb_we_d    = 1'b0;
    coll_d     = coll_q;
    x_d        = x_q;
    y_d        = y_q;
    n_d        = n_q;
    i_d        = i_q;
    s_d        = s_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.clear_in) begin
          state_d = ST_CLEAR;
          clr_d   = '0;
          coll_d  = 1'b0;
        end else if (bus.draw_in) begin
          x_d    = bus.x_in;
          y_d    = bus.y_in;
          n_d    = bus.n_in;
          i_d    = bus.i_in;
          r_d    = 4'd0;
          wait_d = '0;
          coll_d = 1'b0;
          if (bus.n_in != 4'd0) begin
            state_d    = ST_FETCH;
            mem_addr_d = bus.i_in;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_CLEAR: begin
        fb_addr_d = clr_q;
        fb_data_d = 8'h00;
        fb_we_d   = 1'b1;
        clr_d     = clr_q + fb_addr_t'(1);
        if (clr_q == fb_addr_t'(FB_BYTES - 1)) state_d = ST_DONE;
      end
      ST_FETCH: begin
        if (wait_q == MEM_LAST) begin
          s_d       = bus.mem_data_in;
          wait_d    = '0;
          fb_addr_d = {row, col};
          state_d   = ST_RD_L;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_RD_L: begin
        if (wait_q == FB_LAST) begin
          fb_data_d = bus.fb_data_in ^ left_byte;
          fb_we_d   = 1'b1;
          coll_d    = coll_q | (|(bus.fb_data_in & left_byte));
          wait_d    = '0;
          state_d   = ST_WR_L;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_WR_L: begin
        // Aligned sprites touch one byte; the last byte column has no right neighbour.
        if (ofs == 3'd0 || col == 3'd7) begin
          state_d = ST_NEXT;
        end else begin
          fb_addr_d = {row, 3'(col + 3'd1)};
          state_d   = ST_RD_R;
        end
      end
      ST_RD_R: begin
        if (wait_q == FB_LAST) begin
          fb_data_d = bus.fb_data_in ^ right_byte;
          fb_we_d   = 1'b1;
          coll_d    = coll_q | (|(bus.fb_data_in & right_byte));
          wait_d    = '0;
          state_d   = ST_WR_R;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_WR_R: begin
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        r_d        = r_inc[3:0];
        mem_addr_d = i_q + {7'd0, r_inc};
        if (r_inc == {1'b0, n_q} ||
            ({1'b0, y_q} + {1'b0, r_inc}) == 6'(FB_HEIGHT)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d = (state_q == ST_DONE);
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  // Control counters and registered outputs; all cleared by reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wait_q     <= '0;
      r_q        <= '0;
      clr_q      <= '0;
      mem_addr_q <= '0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      fb_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      wait_q     <= wait_d;
      r_q        <= r_d;
      clr_q      <= clr_d;
      mem_addr_q <= mem_addr_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      fb_we_q    <= fb_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      coll_q     <= coll_d;
    end
  end

  // Latched operands and sprite byte; always rewritten before use.
  always_ff @(posedge clk_in) begin
    x_q <= x_d;
    y_q <= y_d;
    n_q <= n_d;
    i_q <= i_d;
    s_q <= s_d;
  end

  assign bus.mem_addr_out  = mem_addr_q;
  assign bus.fb_addr_out   = fb_addr_q;
  assign bus.fb_data_out   = fb_data_q;
  assign bus.fb_we_out     = fb_we_q;
  assign bus.busy_out      = busy_q;
  assign bus.done_out      = done_q;
  assign bus.collision_out = coll_q;

endmodule

// File: tb/tb_chip8_draw_engine.sv
// Directed bench for chip8_draw_engine with 2-cycle sprite memory and
// framebuffer models; expected values are hand-computed constants.
module tb_chip8_draw_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic preload = 1'b0;

  chip8_draw_engine_if bus ();

  chip8_draw_engine #(.MEM_LATENCY(2), .FB_LATENCY(2)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem  [4096];
  logic [7:0] fb   [256];
  logic [7:0] snap [256];
  logic [7:0] m1, f1;
  int wr_total  = 0;
  int bad_total = 0;

  int n_vec = 0;
  int n_err = 0;

  // Sprite memory model: 2-cycle read latency.
  always @(posedge clk) begin
    m1              <= mem[bus.mem_addr_out];
    bus.mem_data_in <= m1;
  end

  // Framebuffer model: 2-cycle read, synchronous write, write counters.
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 256; a++) fb[a] <= 8'hAA;
    end else if (bus.fb_we_out) begin
      fb[bus.fb_addr_out] <= bus.fb_data_out;
    end
    f1             <= fb[bus.fb_addr_out];
    bus.fb_data_in <= f1;
    if (bus.fb_we_out) begin
      wr_total <= wr_total + 1;
      if (bus.fb_addr_out == 8'd0 || bus.fb_addr_out == 8'd248) bad_total <= bad_total + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a command for one cycle; returns at the negedge of the cycle after acceptance.
  task automatic start_op(input logic clr, input logic [5:0] x, input logic [4:0] y,
                          input logic [3:0] n, input logic [11:0] i);
    @(negedge clk);
    bus.clear_in = clr;
    bus.draw_in  = ~clr;
    bus.x_in     = x;
    bus.y_in     = y;
    bus.n_in     = n;
    bus.i_in     = i;
    @(negedge clk);
    bus.clear_in = 1'b0;
    bus.draw_in  = 1'b0;
  endtask

  // Count cycles after acceptance until done_out is seen (bounded).
  task automatic wait_done(input int k0, output int lat);
    int k;
    k = k0;
    while (bus.done_out !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    lat = k;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w0, nz, diff, b0;

    bus.draw_in  = 1'b0;
    bus.clear_in = 1'b0;
    bus.x_in     = '0;
    bus.y_in     = '0;
    bus.n_in     = '0;
    bus.i_in     = '0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    mem[12'h200] = 8'hF0;
    mem[12'h300] = 8'hFF;
    mem[12'h301] = 8'hFF;
    mem[12'h302] = 8'hFF;
    mem[12'h310] = 8'hFF;
    mem[12'h311] = 8'hFF;

    preload = 1'b1;
    rst     = 1'b0;
    repeat (3) @(negedge clk);
    preload = 1'b0;

    check("rst_busy",     32'(bus.busy_out),      32'd0);
    check("rst_done",     32'(bus.done_out),      32'd0);
    check("rst_coll",     32'(bus.collision_out), 32'd0);
    check("rst_we",       32'(bus.fb_we_out),     32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr_out),  32'd0);
    check("rst_fb_addr",  32'(bus.fb_addr_out),   32'd0);
    check("rst_fb_data",  32'(bus.fb_data_out),   32'd0);
    check("preload_b7",   32'(fb[7]),             32'hAA);
    rst = 1'b1;
    @(negedge clk);

    // CLS over a 0xAA-filled framebuffer
    w0 = wr_total;
    start_op(1'b1, 6'd0, 5'd0, 4'd0, 12'h000);
    check("cls_busy", 32'(bus.busy_out), 32'd1);
    wait_done(1, lat);
    check("cls_lat", 32'(lat), 32'd258);
    check("cls_coll", 32'(bus.collision_out), 32'd0);
    @(negedge clk);
    check("cls_writes", 32'(wr_total - w0), 32'd256);
    nz = 0;
    for (int a = 0; a < 256; a++) if (fb[a] != 8'h00) nz++;
    check("cls_nonzero", 32'(nz), 32'd0);

    // aligned draw x=8 y=0 sprite 0xF0, then same draw again
    w0 = wr_total;
    start_op(1'b0, 6'd8, 5'd0, 4'd1, 12'h200);
    wait_done(1, lat);
    check("al_lat", 32'(lat), 32'd10);
    check("al_coll", 32'(bus.collision_out), 32'd0);
    @(negedge clk);
    check("al_byte1", 32'(fb[1]), 32'hF0);
    check("al_writes", 32'(wr_total - w0), 32'd1);

    start_op(1'b0, 6'd8, 5'd0, 4'd1, 12'h200);
    wait_done(1, lat);
    check("al2_coll", 32'(bus.collision_out), 32'd1);
    @(negedge clk);
    check("al2_byte1", 32'(fb[1]), 32'h00);

    // n=0 draw right after a colliding draw
    w0 = wr_total;
    start_op(1'b0, 6'd5, 5'd3, 4'd0, 12'h200);
    check("n0_busy", 32'(bus.busy_out), 32'd0);
    wait_done(1, lat);
    check("n0_lat", 32'(lat), 32'd2);
    check("n0_coll", 32'(bus.collision_out), 32'd0);
    @(negedge clk);
    check("n0_writes", 32'(wr_total - w0), 32'd0);

    // unaligned draw x=3 y=2 sprite 0xFF
    w0 = wr_total;
    start_op(1'b0, 6'd3, 5'd2, 4'd1, 12'h300);
    wait_done(1, lat);
    check("ua_lat", 32'(lat), 32'd14);
    @(negedge clk);
    check("ua_byte16", 32'(fb[16]), 32'h1F);
    check("ua_byte17", 32'(fb[17]), 32'hE0);
    check("ua_writes", 32'(wr_total - w0), 32'd2);

    // corner clip x=62 y=31 n=2
    for (int a = 0; a < 256; a++) snap[a] = fb[a];
    w0 = wr_total;
    b0 = bad_total;
    start_op(1'b0, 6'd62, 5'd31, 4'd2, 12'h310);
    wait_done(1, lat);
    check("clip_lat", 32'(lat), 32'd10);
    @(negedge clk);
    check("clip_byte255", 32'(fb[255]), 32'h03);
    check("clip_writes", 32'(wr_total - w0), 32'd1);
    check("clip_bad_wr", 32'(bad_total - b0), 32'd0);
    diff = 0;
    for (int a = 0; a < 256; a++) if (fb[a] != snap[a]) diff++;
    check("clip_changed", 32'(diff), 32'd1);

    // draw_in during a draw is ignored
    w0 = wr_total;
    start_op(1'b0, 6'd16, 5'd4, 4'd1, 12'h200);
    check("ign_busy", 32'(bus.busy_out), 32'd1);
    bus.draw_in = 1'b1;
    bus.x_in    = 6'd24;
    @(negedge clk);
    bus.draw_in = 1'b0;
    wait_done(2, lat);
    check("ign_lat", 32'(lat), 32'd10);
    @(negedge clk);
    check("ign_byte34", 32'(fb[34]), 32'hF0);
    check("ign_byte35", 32'(fb[35]), 32'h00);
    check("ign_writes", 32'(wr_total - w0), 32'd1);
    repeat (12) @(negedge clk);
    check("ign_no_queue", 32'(wr_total - w0), 32'd1);

    // reset in the middle of an unaligned draw, on a write cycle
    start_op(1'b0, 6'd3, 5'd10, 4'd3, 12'h300);
    lat = 0;
    while (bus.fb_we_out !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("mid_we_seen", 32'(bus.fb_we_out), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(bus.busy_out), 32'd0);
    check("mid_rst_we",   32'(bus.fb_we_out), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // fresh draw after reset: x=40 y=20 sprite 0xF0 -> byte 165
    w0 = wr_total;
    start_op(1'b0, 6'd40, 5'd20, 4'd1, 12'h200);
    wait_done(1, lat);
    check("post_lat", 32'(lat), 32'd10);
    check("post_coll", 32'(bus.collision_out), 32'd0);
    @(negedge clk);
    check("post_byte165", 32'(fb[165]), 32'hF0);
    check("post_writes", 32'(wr_total - w0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/chip8_draw_engine.md
# chip8_draw_engine

- Writer side of the CHIP-8 framebuffer that the HDMI path scans out.
- Executes DRW (XOR a sprite into the framebuffer, report collision) and CLS (zero the framebuffer).
- Sits between the CHIP-8 core's execute stage and the framebuffer BRAM write/read port.
- Sprite bytes come from CHIP-8 main memory.

## Interface
Parameters:
- MEM_LATENCY, 2, cycles from mem_addr_out to valid mem_data_in
- FB_LATENCY, 2, cycles from fb_addr_out to valid fb_data_in

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-low reset
- draw_in  input  1  start DRW; sampled only in IDLE
- clear_in  input  1  start CLS; sampled only in IDLE; wins over draw_in
- x_in  input  6  sprite column, 0..63; latched at start
- y_in  input  5  sprite row, 0..31; latched at start
- n_in  input  4  sprite height in rows; latched at start
- i_in  input  12  sprite base address; latched at start
- mem_addr_out  output  12  sprite byte address
- mem_data_in  input  8  sprite byte
- fb_addr_out  output  8  framebuffer byte address = row*8 + col[5:3]
- fb_data_in  input  8  framebuffer read data
- fb_data_out  output  8  framebuffer write data
- fb_we_out  output  1  framebuffer write enable
- busy_out  output  1  operation in progress
- done_out  output  1  one-cycle completion pulse
- collision_out  output  1  VF result; valid when done_out is high, held until the next start

## Operation
- Framebuffer: 256 bytes, MSB = leftmost pixel.
- States: IDLE, CLEAR, FETCH, RD_L, WR_L, RD_R, WR_R, NEXT, DONE.
- IDLE:
  - clear_in=1 -> CLEAR.
  - Else draw_in=1 and n_in≠0 -> FETCH.
  - Else draw_in=1 and n_in=0 -> DONE with collision 0; no memory or framebuffer access.
- CLEAR:
  - Writes 0x00 to addresses 0..255, one per cycle, in ascending order.
  - After address 255 -> DONE; collision_out=0.
- FETCH:
  - Drive mem_addr_out = i + r (12-bit wrap).
  - Wait MEM_LATENCY, then latch the sprite byte s.
- Shifting: o = x[2:0]; left byte L = s >> o; right byte R = (s << (8-o))[7:0].
- RD_L: address = (y+r)*8 + x[5:3]; wait FB_LATENCY, latch old byte.
- WR_L:
  - Write old ^ L.
  - collision |= |(old & L).
- RD_R/WR_R:
  - Same as RD_L/WR_L for byte column x[5:3]+1.
  - Skipped when o=0 or x[5:3]=7 (right-edge clip; no horizontal wrap).
- NEXT:
  - r increments.
  - -> DONE when r=n or y+r=32 (bottom clip; no vertical wrap).
  - Otherwise -> FETCH.
- DONE: done_out=1 for one cycle, busy_out=0, then IDLE.
- Address math is on 8 bits; clipping guarantees that no address ≥256 is generated.
- Start pulses while busy: ignored, not queued.
- Reset: FSM to IDLE immediately; no rollback of partially written framebuffer bytes.

## Timing
Reset values:
- busy_out 0, done_out 0, collision_out 0, fb_we_out 0
- mem_addr_out 0, fb_addr_out 0, fb_data_out 0

Outputs:
- All outputs registered.
- busy_out rises the cycle after start acceptance.
- fb_addr_out is held stable across each RD and its following WR.
- fb_we_out is high exactly one cycle per written byte.

Per-row cost with default latencies:
- FETCH 3 cycles, RD 3 each, WR 1 each, NEXT 1.
- Aligned row: 8 cycles. Unaligned row: 12 cycles.

Completion:
- done_out asserts the cycle after NEXT exits.
- CLEAR: done_out asserts 258 cycles after acceptance; 256 writes.
- n=0 draw: done_out asserts 2 cycles after acceptance.

Reset mid-operation: fb_we_out is 0 on the cycle after rst_in is sampled low.

## Structure
- chip8_pkg holds:
  - FB_WIDTH=64, FB_HEIGHT=32, FB_BYTES=256
  - fb_addr_t (8 bits)
  - draw_state_t enum
- The framebuffer scan-out path also imports these.
- No sub-module: the shifter and collision logic are a few lines inline.
- Latency waits use one shared wait counter sized for max(MEM_LATENCY, FB_LATENCY).

## Test plan
- Preload the framebuffer with 0xAA; pulse clear_in.
  - All 256 bytes read 0x00; done_out 258 cycles after acceptance; collision_out=0.
- x=8, y=0, n=1, mem[0x200]=0xF0, i=0x200, empty framebuffer:
  - Byte 1 = 0xF0; collision_out=0.
  - Repeat the same draw: byte 1 = 0x00; collision_out=1.
- x=3, y=2, n=1, sprite 0xFF:
  - Byte 16 = 0x1F, byte 17 = 0xE0.
  - Exactly 2 writes; 12-cycle row.
- x=62, y=31, n=2, sprites 0xFF,0xFF:
  - Only byte 255 changes, to 0x03.
  - No write to bytes 0 or 248; done after one row.
- n=0 draw: zero fb_we_out cycles; done 2 cycles after acceptance; collision_out=0.
- Assert draw_in during a draw: ignored.
- Drop rst_in mid-unaligned draw: busy_out=0 and fb_we_out=0 next cycle.
- Issue a fresh draw after reset: completes correctly.
